// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice.
//   dmem_arb_state_e : arbitration FSM states (free / aux locked burst)
//   DMEM_OWN_*       : read-owner tag carried from grant to read return
//   WAIT_CNT_W       : width of the aux starvation counter (AUX_WAIT_MAX <= 15)
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic {
        DMEM_ARB_FREE = 1'b0,
        DMEM_ARB_LOCK = 1'b1
    } dmem_arb_state_e;

    localparam logic DMEM_OWN_CPU = 1'b0;
    localparam logic DMEM_OWN_AUX = 1'b1;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_arb_rsp.sv
// -----------------------------------------------------------------------------
// dmem_arb_rsp
// Read-return path: remembers which requester issued the read granted last
// cycle and steers the memory's 1-cycle-late read data to it.
// Ports:
//   clk, resetn        : clock, synchronous active-low reset
//   rd_issue_i         : a read was granted this cycle
//   rd_owner_i         : owner of that read (DMEM_OWN_CPU / DMEM_OWN_AUX)
//   mem_q_i            : memory read data
//   cpu_rvalid_o/rdata : CPU read response
//   aux_rvalid_o/rdata : aux read response
// -----------------------------------------------------------------------------
module dmem_arb_rsp
    import dmem_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        rd_issue_i,
    input  logic        rd_owner_i,
    input  logic [31:0] mem_q_i,
    output logic        cpu_rvalid_o,
    output logic [31:0] cpu_rdata_o,
    output logic        aux_rvalid_o,
    output logic [31:0] aux_rdata_o
);

    logic rd_pend_q;
    logic rd_owner_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= DMEM_OWN_CPU;
        end else begin
            rd_pend_q  <= rd_issue_i;
            rd_owner_q <= rd_owner_i;
        end
    end

    // resetn gating keeps a read issued just before reset from surfacing
    // while reset is being applied.
    assign cpu_rvalid_o = resetn & rd_pend_q & (rd_owner_q == DMEM_OWN_CPU);
    assign aux_rvalid_o = resetn & rd_pend_q & (rd_owner_q == DMEM_OWN_AUX);
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_q_i : 32'h0;
    assign aux_rdata_o  = aux_rvalid_o ? mem_q_i : 32'h0;

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates the single-port data memory between the CPU MEM stage (port 0)
// and an auxiliary master (port 1), with locked aux bursts and aux starvation
// protection.
// Handshake: a requester holds req_i (and its bundle) stable until it sees
// gnt_o high in the same cycle; gnt_o is combinational and the access is
// issued to memory in that cycle. Read data returns on rvalid_o exactly one
// cycle after the grant; writes never produce rvalid_o.
// Ports:
//   clk, resetn              : clock, synchronous active-low reset
//   cpu_* / aux_*            : request bundles and responses
//   aux_lock_i               : keep ownership after this aux grant
//   cpu_stall_o              : cpu_req_i & ~cpu_gnt_o
//   mem_*                    : memory interface (active-low ceb/web)
//   dbg_state_o              : FSM state (0=free, 1=aux locked)
//   dbg_aux_wait_o           : aux starvation counter
//   perf_conflict_o          : cycles with both requests high   (DMEM_ARB_PERF_EN)
//   perf_cpu_stall_o         : cycles with cpu_stall_o high     (DMEM_ARB_PERF_EN)
// Build option: define DMEM_ARB_PERF_EN to add the saturating perf counters.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW           = 10,
    parameter int AUX_WAIT_MAX = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [AW-1:0]         cpu_addr_i,
    input  logic [3:0]            cpu_mask_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [31:0]           cpu_rdata_o,
    input  logic                  aux_req_i,
    input  logic                  aux_we_i,
    input  logic [AW-1:0]         aux_addr_i,
    input  logic [3:0]            aux_mask_i,
    input  logic [31:0]           aux_wdata_i,
    input  logic                  aux_lock_i,
    output logic                  aux_gnt_o,
    output logic                  aux_rvalid_o,
    output logic [31:0]           aux_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_ceb_o,
    output logic                  mem_web_o,
    output logic [AW-1:0]         mem_addr_o,
    output logic [3:0]            mem_mask_o,
    output logic [31:0]           mem_d_o,
    input  logic [31:0]           mem_q_i,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]           perf_conflict_o,
    output logic [15:0]           perf_cpu_stall_o,
`endif
    output logic                  dbg_state_o,
    output logic [WAIT_CNT_W-1:0] dbg_aux_wait_o
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = WAIT_CNT_W'(AUX_WAIT_MAX);

    dmem_arb_state_e       state_q, state_d;
    logic [WAIT_CNT_W-1:0] aux_wait_q, aux_wait_d;
    logic                  aux_force;
    logic                  rd_issue;
    logic                  rd_owner;

    assign aux_force = aux_req_i & (aux_wait_q == WAIT_MAX);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= DMEM_ARB_FREE;
            aux_wait_q <= '0;
        end else begin
            state_q    <= state_d;
            aux_wait_q <= aux_wait_d;
        end
    end

    // Arbitration and next state. Grants are suppressed while resetn is low.
    always_comb begin
        state_d   = state_q;
        cpu_gnt_o = 1'b0;
        aux_gnt_o = 1'b0;
        if (resetn) begin
            case (state_q)
                DMEM_ARB_FREE: begin
                    if (aux_force) begin
                        aux_gnt_o = 1'b1;
                    end else if (cpu_req_i) begin
                        cpu_gnt_o = 1'b1;
                    end else if (aux_req_i) begin
                        aux_gnt_o = 1'b1;
                    end
                    if (aux_gnt_o && aux_lock_i) begin
                        state_d = DMEM_ARB_LOCK;
                    end
                end
                DMEM_ARB_LOCK: begin
                    aux_gnt_o = aux_req_i;
                    // The lock ends with any cycle where aux drops aux_lock_i,
                    // even an idle one.
                    if (!aux_lock_i) begin
                        state_d = DMEM_ARB_FREE;
                    end
                end
                default: state_d = DMEM_ARB_FREE;
            endcase
        end
    end

    // Starvation counter: saturates at WAIT_MAX, which forces the next aux win.
    always_comb begin
        aux_wait_d = aux_wait_q;
        if (aux_gnt_o) begin
            aux_wait_d = '0;
        end else if (aux_req_i && (aux_wait_q != WAIT_MAX)) begin
            aux_wait_d = aux_wait_q + 1'b1;
        end
    end

    // Memory-side mux; all data fields are zero when nothing is granted.
    always_comb begin
        mem_ceb_o  = 1'b1;
        mem_web_o  = 1'b1;
        mem_addr_o = '0;
        mem_mask_o = 4'h0;
        mem_d_o    = 32'h0;
        if (cpu_gnt_o) begin
            mem_ceb_o  = 1'b0;
            mem_web_o  = ~cpu_we_i;
            mem_addr_o = cpu_addr_i;
            mem_mask_o = cpu_we_i ? cpu_mask_i : 4'h0;
            mem_d_o    = cpu_wdata_i;
        end else if (aux_gnt_o) begin
            mem_ceb_o  = 1'b0;
            mem_web_o  = ~aux_we_i;
            mem_addr_o = aux_addr_i;
            mem_mask_o = aux_we_i ? aux_mask_i : 4'h0;
            mem_d_o    = aux_wdata_i;
        end
    end

    assign cpu_stall_o    = cpu_req_i & ~cpu_gnt_o;
    assign rd_issue       = (cpu_gnt_o & ~cpu_we_i) | (aux_gnt_o & ~aux_we_i);
    assign rd_owner       = aux_gnt_o ? DMEM_OWN_AUX : DMEM_OWN_CPU;
    assign dbg_state_o    = state_q;
    assign dbg_aux_wait_o = aux_wait_q;

    dmem_arb_rsp u_rsp (
        .clk          (clk),
        .resetn       (resetn),
        .rd_issue_i   (rd_issue),
        .rd_owner_i   (rd_owner),
        .mem_q_i      (mem_q_i),
        .cpu_rvalid_o (cpu_rvalid_o),
        .cpu_rdata_o  (cpu_rdata_o),
        .aux_rvalid_o (aux_rvalid_o),
        .aux_rdata_o  (aux_rdata_o)
    );

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_conflict_q, perf_conflict_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_conflict_d = perf_conflict_q;
        perf_stall_d    = perf_stall_q;
        if (cpu_req_i && aux_req_i && (perf_conflict_q != 16'hFFFF)) begin
            perf_conflict_d = perf_conflict_q + 16'd1;
        end
        if (cpu_stall_o && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_conflict_q <= 16'h0;
            perf_stall_q    <= 16'h0;
        end else begin
            perf_conflict_q <= perf_conflict_d;
            perf_stall_q    <= perf_stall_d;
        end
    end

    assign perf_conflict_o  = perf_conflict_q;
    assign perf_cpu_stall_o = perf_stall_q;
`endif

endmodule
